// File: rtl/debounce_filter.sv
// debounce_filter: single-bit stability filter with rise/fall event pulses.
// Define DEBOUNCE_FILTER_SPECIFY_DELAYS_EN for clk->q path delays and a d setup check.
module debounce_filter #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

  logic             d_r;
  logic [CNT_W-1:0] cnt;
  logic             commit;

  assign busy   = d_r ^ q;
  assign commit = busy && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r  <= 1'b0;
      cnt  <= '0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      d_r  <= d;
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (1'b1)
        !busy: begin
          cnt <= '0;
        end
        commit: begin
          q    <= d_r;
          cnt  <= '0;
          rise <= d_r;
          fall <= ~d_r;
        end
        default: begin
          cnt <= cnt + CNT_W'(1);
        end
      endcase
    end
  end

`ifdef DEBOUNCE_FILTER_SPECIFY_DELAYS_EN
  specify
    specparam tRise_clk_q = 150;
    specparam tFall_clk_q = 200;
    specparam tSetup      = 70;
    (clk => q)    = (tRise_clk_q, tFall_clk_q);
    (clk => rise) = (tRise_clk_q, tFall_clk_q);
    (clk => fall) = (tRise_clk_q, tFall_clk_q);
    $setup(d, posedge clk, tSetup);
  endspecify
`else
  // zero-delay outputs, no timing checks
`endif

endmodule

// File: tb/tb_debounce_filter.sv
// tb_debounce_filter: random d/reset stimulus on three filter depths,
// checked against a sliding-window reference model.
module tb_debounce_filter;

  logic       clk;
  logic       rst_n;
  logic       d;
  logic [2:0] q;
  logic [2:0] rise;
  logic [2:0] fall;
  logic [2:0] busy;

  int n_chk;
  int n_pass;

  int   depth [3] = '{4, 1, 8};
  logic h [$];
  logic m_dr;
  logic mq [3];
  logic mr [3];
  logic mf [3];

  debounce_filter u_d4 (
    .clk(clk), .rst_n(rst_n), .d(d),
    .q(q[0]), .rise(rise[0]), .fall(fall[0]), .busy(busy[0])
  );

  debounce_filter #(.STABLE_CNT(1), .CNT_W(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .d(d),
    .q(q[1]), .rise(rise[1]), .fall(fall[1]), .busy(busy[1])
  );

  debounce_filter #(.STABLE_CNT(8), .CNT_W(3)) u_d8 (
    .clk(clk), .rst_n(rst_n), .d(d),
    .q(q[2]), .rise(rise[2]), .fall(fall[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #15 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    h.delete();
    m_dr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mq[k] = 1'b0;
      mr[k] = 1'b0;
      mf[k] = 1'b0;
    end
  endtask

  // q flips once the last depth sampled values all disagree with it
  task automatic model_step();
    logic c;
    h.push_back(m_dr);
    if (h.size() > 16) void'(h.pop_front());
    for (int k = 0; k < 3; k++) begin
      c = (h.size() >= depth[k]);
      if (c)
        for (int j = 0; j < depth[k]; j++)
          if (h[h.size() - 1 - j] == mq[k]) c = 1'b0;
      mr[k] = c && !mq[k];
      mf[k] = c && mq[k];
      if (c) mq[k] = ~mq[k];
    end
    m_dr = d;
  endtask

  task automatic compare(input string ph);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_q%0d", ph, depth[k]), q[k], mq[k]);
      chk($sformatf("%s_rise%0d", ph, depth[k]), rise[k], mr[k]);
      chk($sformatf("%s_fall%0d", ph, depth[k]), fall[k], mf[k]);
      chk($sformatf("%s_busy%0d", ph, depth[k]), busy[k], m_dr ^ mq[k]);
    end
  endtask

  initial begin
    int hold;
    n_chk  = 0;
    n_pass = 0;
    hold   = 0;
    rst_n  = 1'b0;
    d      = 1'b1;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      compare("rst");
    end
    rst_n = 1'b1;
    d     = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare("run");
      if (cyc == 200 || $urandom_range(0, 59) == 0) begin
        #5 rst_n = 1'b0;
        model_reset();
        #1 compare("arst");
        #4 rst_n = 1'b1;
      end
      if (hold == 0) begin
        d    = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 11);
      end
      hold--;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/debounce_filter.md
# debounce_filter

Single-bit stability filter that consumes the registered bit from an upstream path-delayed DFF stage and propagates a change only after it has held for a programmable number of consecutive clock edges. Emits one-cycle rise and fall event pulses alongside the filtered level. Sits directly downstream of the DFF and shares its clock. Optional specify-block path delays and a setup check keep it usable in delay-modelling simulations.

## Interface

Parameters:
- `STABLE_CNT`, default 4: consecutive mismatching compare edges required before `q` updates. Legal range is 1 to 2^`CNT_W`.
- `CNT_W`, default 3: width of the stability counter. Must satisfy 2^`CNT_W` >= `STABLE_CNT`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  rising-edge clock, same clock as the upstream DFF.
- `rst_n`  input  1  asynchronous, active-low reset.
- `d`  input  1  raw bit from the upstream DFF `q`.
- `q`  output  1  filtered level.
- `rise`  output  1  one-cycle pulse on a filtered 0->1 transition.
- `fall`  output  1  one-cycle pulse on a filtered 1->0 transition.
- `busy`  output  1  high while a candidate change is being qualified.

## Operation

Reset:
- `rst_n` low clears `d_r`, `cnt`, `q`, `rise` and `fall` to 0 immediately, with no wait for `clk`.
- `busy` is therefore 0 during reset.
- Release takes effect at the first `clk` rising edge with `rst_n` high.

Every rising edge, in parallel:
- `d_r` <= `d` (sample register).
- `rise` and `fall` default to 0.

Compare logic on each edge (uses pre-edge `d_r`, `q`, `cnt`):
- If `d_r` == `q` (IDLE): `cnt` <= 0.
- If `d_r` != `q` and `cnt` < `STABLE_CNT`-1 (COUNT): `cnt` <= `cnt`+1.
- If `d_r` != `q` and `cnt` == `STABLE_CNT`-1 (COMMIT):
  - `q` <= `d_r` and `cnt` <= 0.
  - `rise` <= `d_r`; `fall` <= ~`d_r`.

Other rules:
- `busy` = (`d_r` != `q`), combinational from registers.
- The state is implicit: IDLE when `busy`=0, COUNT when `busy`=1. COMMIT returns to IDLE on the next edge.
- A glitch occurs when `d_r` returns to `q` before COMMIT. The counter clears with no output activity. A later mismatch restarts counting from 0.
- With `STABLE_CNT`=1, `q` follows `d_r` one edge later. Every change produces a pulse.
- `rise` and `fall` are never high together. Pulses are always exactly one cycle wide.
- The counter never exceeds `STABLE_CNT`-1. There is no wrap-around.

## Timing

- Say `d` is stable before edge e0 and captured into `d_r` at e0. Compares occur at e1..e`STABLE_CNT`.
  - `q` and the pulse change at edge e`STABLE_CNT`, i.e. `STABLE_CNT`+1 edges after `d` first settles.
  - Default: `d` settles before e0, `q` changes at e4, and `rise`/`fall` is high from e4 to e5.
- `busy` rises one edge after the `d` change (at e0). It falls at the COMMIT edge or at the glitch-return edge.
- Reset asserted mid-count: all state clears asynchronously and no pulse is emitted. After release, a `d` still at 1 requalifies from `cnt`=0.
- Without `SPECIFY_DELAYS_EN`, outputs change in zero delay after the edge.

## Configuration

Macro: `DEBOUNCE_FILTER_SPECIFY_DELAYS_EN`.

Defined:
- A specify block with specparams `tRise_clk_q`=150, `tFall_clk_q`=200 and `tSetup`=70.
- Path delays (`clk` => `q`), (`clk` => `rise`) and (`clk` => `fall`) = (`tRise_clk_q`, `tFall_clk_q`).
- `$setup(d, posedge clk, tSetup)` is checked.

Undefined:
- No specify block.
- Function and cycle behaviour are identical; only output delays and the setup check are absent.

## Test plan

Use a 30-time-unit clock, defaults unless noted. Edge numbering follows the Timing section.

- **Reset:** hold `rst_n`=0 with `d`=1 for 3 edges -> `q`=`rise`=`fall`=`busy`=0 throughout.
- **Clean rise:** `d` 0->1 before e0 and held -> `busy`=1 from e0; `q`=1 and `rise`=1 at e4; `rise`=0 at e5; `busy`=0 after e4.
- **Glitch:** `d`=1 for 2 cycles then back to 0 -> `cnt` reaches 2 then clears; `q` stays 0; `rise` never asserts.
- **Clean fall:** from `q`=1, `d` 1->0 held -> `q`=0 and `fall`=1 at e4, one cycle only; `rise` stays 0.
- **Reset mid-count:** `d`=1 held, pulse `rst_n` low between e2 and e3 -> `cnt`=0 and `q`=0 immediately; after release, `q`=1 four compare edges later.
- **`STABLE_CNT`=1:** toggle `d` every cycle -> `q` tracks `d` delayed by two edges; a `rise` or `fall` pulse on every edge after the first transition.
